// File: rtl/contador_decrescente_bcd_if.sv
// Control/data bundle for the BCD down-counter.
// The master drives the load/enable side and the slave returns the count and status pulses.
interface contador_decrescente_bcd_if #(
  parameter int DIGITS = 2
);
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic                  enable;
  logic [4*DIGITS-1:0]   count;
  logic                  zero;
  logic                  done;
  logic                  load_err;

  modport master (
    output load, load_value, enable,
    input  count, zero, done, load_err
  );

  modport slave (
    input  load, load_value, enable,
    output count, zero, done, load_err
  );
endinterface

// File: rtl/contador_decrescente_bcd.sv
// Multi-digit BCD down-counter with validated load, expiry pulse and optional auto-reload.
// When AUTO_RELOAD is set, loading N gives a periodic done tick every N+1 enabled cycles.
module contador_decrescente_bcd #(
  parameter int DIGITS      = 2,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic clk,
  input  logic reset,
  contador_decrescente_bcd_if.slave bus
);
  localparam int W = 4 * DIGITS;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   reload_q, reload_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic [DIGITS-1:0] digit_bad;
  logic [DIGITS-1:0] borrow;
  logic [W-1:0]      dec_value;

  // Per-digit load validation and ripple-borrow decrement; digit 0 always borrows.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] cur;
      assign cur            = count_q[4*gi +: 4];
      assign digit_bad[gi]  = (bus.load_value[4*gi +: 4] > 4'd9);
      assign dec_value[4*gi +: 4] = !borrow[gi] ? cur :
                                    (cur == 4'd0) ? 4'd9 : cur - 4'd1;
      if (gi == 0) begin : g_first
        assign borrow[gi] = 1'b1;
      end
      if (gi < DIGITS - 1) begin : g_chain
        assign borrow[gi+1] = borrow[gi] && (cur == 4'd0);
      end
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    if (bus.load) begin
      if (|digit_bad) begin
        err_d = 1'b1;
      end else begin
        count_d  = bus.load_value;
        reload_d = bus.load_value;
        state_d  = (bus.load_value != '0) ? RUN : IDLE;
      end
    end else if (state_q == RUN && bus.enable) begin
      if (count_q != '0) begin
        count_d = dec_value;
        if (dec_value == '0) begin
          done_d = 1'b1;
          if (!AUTO_RELOAD) state_d = IDLE;
        end
      end else if (AUTO_RELOAD) begin
        count_d = reload_q;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.zero     = (count_q == '0);
  assign bus.done     = done_q;
  assign bus.load_err = err_q;
endmodule

// File: tb/tb_contador_decrescente_bcd.sv
// Scoreboard bench for the BCD down-counter: three instances (1 digit auto-reload,
// 2 digits stop-at-zero, 3 digits stop-at-zero) exercised one at a time.
module tb_contador_decrescente_bcd;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  contador_decrescente_bcd_if #(.DIGITS(1)) if1 ();
  contador_decrescente_bcd_if #(.DIGITS(2)) if2 ();
  contador_decrescente_bcd_if #(.DIGITS(3)) if3 ();

  contador_decrescente_bcd #(.DIGITS(1), .AUTO_RELOAD(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  contador_decrescente_bcd #(.DIGITS(2), .AUTO_RELOAD(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(if2));
  contador_decrescente_bcd #(.DIGITS(3), .AUTO_RELOAD(1'b0)) dut3 (.clk(clk), .reset(reset), .bus(if3));

  typedef struct {
    int          id;
    logic [15:0] cnt;
    logic        zero;
    logic        done;
    logic        err;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  event sample_ev;

  always @(posedge clk) begin
    #1;
    -> sample_ev;
  end

  // Monitor: pops one expectation per sample point and compares against the addressed DUT.
  initial begin
    forever begin
      @(sample_ev);
      if (sb_q.size() != 0) begin
        exp_t        e;
        logic [15:0] a_cnt;
        logic        a_zero, a_done, a_err;
        e = sb_q.pop_front();
        a_cnt = '0; a_zero = 1'b0; a_done = 1'b0; a_err = 1'b0;
        case (e.id)
          1: begin a_cnt = {12'd0, if1.count}; a_zero = if1.zero; a_done = if1.done; a_err = if1.load_err; end
          2: begin a_cnt = {8'd0, if2.count};  a_zero = if2.zero; a_done = if2.done; a_err = if2.load_err; end
          default: begin a_cnt = {4'd0, if3.count}; a_zero = if3.zero; a_done = if3.done; a_err = if3.load_err; end
        endcase
        vectors++;
        if (a_cnt !== e.cnt || a_zero !== e.zero || a_done !== e.done || a_err !== e.err) begin
          miscompares++;
          $display("FAIL %s dut%0d: got count=%h zero=%b done=%b load_err=%b, want count=%h zero=%b done=%b load_err=%b",
                   e.tag, e.id, a_cnt, a_zero, a_done, a_err, e.cnt, e.zero, e.done, e.err);
        end else begin
          $display("ok   %s dut%0d: count=%h zero=%b done=%b load_err=%b",
                   e.tag, e.id, a_cnt, a_zero, a_done, a_err);
        end
      end
    end
  end

  function automatic logic [15:0] bcd(input int n);
    logic [15:0] r;
    r[3:0]   = 4'(n % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[15:12] = 4'((n / 1000) % 10);
    return r;
  endfunction

  task automatic push(input int id, input logic [15:0] ec, input bit ed, input bit ee, input string tag);
    exp_t e;
    e.id = id; e.cnt = ec; e.zero = (ec == 16'd0); e.done = ed; e.err = ee; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic clear_inputs();
    if1.load = 1'b0; if1.load_value = '0; if1.enable = 1'b0;
    if2.load = 1'b0; if2.load_value = '0; if2.enable = 1'b0;
    if3.load = 1'b0; if3.load_value = '0; if3.enable = 1'b0;
  endtask

  // Drive one cycle of stimulus at the falling edge and record what the next rising edge must produce.
  task automatic step(input int id, input bit ld, input logic [15:0] lv, input bit en,
                      input logic [15:0] ec, input bit ed, input bit ee, input string tag);
    clear_inputs();
    case (id)
      1: begin if1.load = ld; if1.load_value = lv[3:0];  if1.enable = en; end
      2: begin if2.load = ld; if2.load_value = lv[7:0];  if2.enable = en; end
      default: begin if3.load = ld; if3.load_value = lv[11:0]; if3.enable = en; end
    endcase
    push(id, ec, ed, ee, tag);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    reset = 1'b0;
    #1;
    for (int id = 1; id <= 3; id++) begin
      push(id, 16'd0, 1'b0, 1'b0, "reset_state");
      -> sample_ev;
      #1;
    end
    @(negedge clk);
    reset = 1'b1;

    // 3 digits: borrow across two digits, enable gaps, rejected high-digit load
    step(3, 1, 16'h100, 0, 16'h100, 0, 0, "c_load_100");
    step(3, 0, 16'h000, 1, 16'h099, 0, 0, "c_dec_borrow");
    step(3, 0, 16'h000, 0, 16'h099, 0, 0, "c_hold1");
    step(3, 0, 16'h000, 0, 16'h099, 0, 0, "c_hold2");
    step(3, 0, 16'h000, 1, 16'h098, 0, 0, "c_dec");
    step(3, 1, 16'hA00, 0, 16'h098, 0, 1, "c_bad_load");
    step(3, 0, 16'h000, 1, 16'h097, 0, 0, "c_still_run");

    // 1 digit with auto-reload: 9..0 repeating, done at every 0
    step(1, 1, 16'h9, 0, 16'h9, 0, 0, "b_load_9");
    for (int k = 1; k <= 22; k++) begin
      int v;
      v = (9 - k + 30) % 10;
      step(1, 0, 16'h0, 1, bcd(v), (v == 0), 0, "b_tick");
    end
    step(1, 1, 16'hC, 0, 16'h7, 0, 1, "b_bad_load");
    step(1, 0, 16'h0, 1, 16'h6, 0, 0, "b_after_bad");

    // 2 digits, stop at zero: full 25..00 run with a single done pulse
    step(2, 1, 16'h25, 1, 16'h25, 0, 0, "a_load_25_wins");
    for (int n = 24; n >= 0; n--)
      step(2, 0, 16'h0, 1, bcd(n), (n == 0), 0, "a_count");
    step(2, 0, 16'h0, 1, 16'h00, 0, 0, "a_stopped1");
    step(2, 0, 16'h0, 1, 16'h00, 0, 0, "a_stopped2");
    step(2, 1, 16'h12, 0, 16'h12, 0, 0, "a_load_12");
    step(2, 0, 16'h0,  1, 16'h11, 0, 0, "a_dec_11");
    step(2, 1, 16'h3A, 0, 16'h11, 0, 1, "a_bad_3a");
    step(2, 0, 16'h0,  1, 16'h10, 0, 0, "a_run_kept");
    step(2, 1, 16'h00, 0, 16'h00, 0, 0, "a_load_zero");
    step(2, 0, 16'h0,  1, 16'h00, 0, 0, "a_zero_idle");
    step(2, 1, 16'h08, 0, 16'h08, 0, 0, "a_load_08");
    step(2, 0, 16'h0,  1, 16'h07, 0, 0, "a_dec_07");
    step(2, 1, 16'h40, 1, 16'h40, 0, 0, "a_load_over_en");
    step(2, 0, 16'h0,  1, 16'h39, 0, 0, "a_dec_39");

    // Asynchronous reset between edges must clear the count at once
    #2;
    reset = 1'b0;
    #1;
    push(2, 16'h00, 0, 0, "a_async_reset");
    -> sample_ev;
    #1;
    reset = 1'b1;
    @(negedge clk);
    step(2, 0, 16'h0, 1, 16'h00, 0, 0, "a_idle_after_rst1");
    step(2, 0, 16'h0, 1, 16'h00, 0, 0, "a_idle_after_rst2");

    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
